// File: rtl/comp_sched.sv
`default_nettype none
// ============================================================================
// Module   : comp_sched
// Purpose  : Round-robin scheduler that time-shares one unsigned magnitude
//            comparator (gt/lt/eq) among NREQ = 2**IDW requesters. A granted
//            operand pair is registered, compared in the following cycle and
//            returned as a tagged result on a single backpressured channel.
// Ports    : Clk        - system clock, rising-edge active
//            Rst        - synchronous active-low reset
//            req_valid  - per-requester operand-pair pending
//            req_a/req_b- packed operands, requester i at [i*DATAWIDTH +: DATAWIDTH]
//            req_ready  - one-hot (or zero) accept strobe
//            rsp_valid  - result available
//            rsp_ready  - consumer accepts result
//            rsp_id     - index of the requester owning the result
//            rsp_gt/lt/eq - result flags (a>b, a<b, a==b)
//            busy       - registered, high whenever not idle
// Revision : 1.0 - initial release
// ============================================================================
module comp_sched #(
  parameter int DATAWIDTH = 16,
  parameter int IDW       = 2
) (
  input  logic                         Clk,
  input  logic                         Rst,
  input  logic [(1<<IDW)-1:0]          req_valid,
  input  logic [(1<<IDW)*DATAWIDTH-1:0] req_a,
  input  logic [(1<<IDW)*DATAWIDTH-1:0] req_b,
  output logic [(1<<IDW)-1:0]          req_ready,
  output logic                         rsp_valid,
  input  logic                         rsp_ready,
  output logic [IDW-1:0]               rsp_id,
  output logic                         rsp_gt,
  output logic                         rsp_lt,
  output logic                         rsp_eq,
  output logic                         busy
);

  localparam int NREQ = 1 << IDW;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_CMP  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;

  logic [IDW-1:0]       r_ptr;
  logic [DATAWIDTH-1:0] r_op_a;
  logic [DATAWIDTH-1:0] r_op_b;
  logic [IDW-1:0]       r_id_q;
  logic [IDW-1:0]       r_rsp_id;
  logic                 r_rsp_gt;
  logic                 r_rsp_lt;
  logic                 r_rsp_eq;
  logic                 r_rsp_valid;
  logic                 r_busy;

  logic                 w_found;
  logic [IDW-1:0]       w_grant;
  logic [IDW-1:0]       w_idx;
  logic                 w_accept;
  logic [NREQ-1:0]      w_onehot;
  logic [DATAWIDTH-1:0] w_sel_a;
  logic [DATAWIDTH-1:0] w_sel_b;
  logic                 w_gt;
  logic                 w_lt;
  logic                 w_eq;

  // Round-robin search starting at r_ptr; the IDW-bit add wraps modulo NREQ.
  always_comb begin
    w_found = 1'b0;
    w_grant = r_ptr;
    w_idx   = r_ptr;
    for (int k = 0; k < NREQ; k++) begin
      w_idx = r_ptr + IDW'(k);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_grant = w_idx;
      end
    end
  end

  // Operand mux for the granted requester.
  always_comb begin
    w_sel_a  = '0;
    w_sel_b  = '0;
    w_onehot = '0;
    for (int k = 0; k < NREQ; k++) begin
      if (IDW'(k) == w_grant) begin
        w_sel_a     = req_a[k*DATAWIDTH +: DATAWIDTH];
        w_sel_b     = req_b[k*DATAWIDTH +: DATAWIDTH];
        w_onehot[k] = 1'b1;
      end
    end
  end

  // The single shared comparator: lt takes priority, then gt, otherwise eq.
  always_comb begin
    w_lt = (r_op_a < r_op_b);
    w_gt = !w_lt && (r_op_a > r_op_b);
    w_eq = !w_lt && !w_gt;
  end

  // Next-state logic. Reset gating of the accept lives here so that a
  // request coinciding with reset is never acknowledged.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_found && Rst) begin
          w_accept    = 1'b1;
          w_state_nxt = ST_CMP;
        end
      end
      ST_CMP: begin
        w_state_nxt = ST_RESP;
      end
      ST_RESP: begin
        if (rsp_ready) begin
          w_state_nxt = ST_IDLE;
        end
      end
      default: begin
        w_state_nxt = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst) begin
      r_state     <= ST_IDLE;
      r_ptr       <= '0;
      r_op_a      <= '0;
      r_op_b      <= '0;
      r_id_q      <= '0;
      r_rsp_id    <= '0;
      r_rsp_gt    <= 1'b0;
      r_rsp_lt    <= 1'b0;
      r_rsp_eq    <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_busy      <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_busy  <= (w_state_nxt != ST_IDLE);
      if (w_accept) begin
        r_op_a <= w_sel_a;
        r_op_b <= w_sel_b;
        r_id_q <= w_grant;
        r_ptr  <= w_grant + IDW'(1);
      end
      if (r_state == ST_CMP) begin
        r_rsp_gt    <= w_gt;
        r_rsp_lt    <= w_lt;
        r_rsp_eq    <= w_eq;
        r_rsp_id    <= r_id_q;
        r_rsp_valid <= 1'b1;
      end
      if (r_state == ST_RESP && rsp_ready) begin
        r_rsp_valid <= 1'b0;
      end
    end
  end

  assign req_ready = w_accept ? w_onehot : '0;
  assign rsp_valid = r_rsp_valid;
  assign rsp_id    = r_rsp_id;
  assign rsp_gt    = r_rsp_gt;
  assign rsp_lt    = r_rsp_lt;
  assign rsp_eq    = r_rsp_eq;
  assign busy      = r_busy;

endmodule
`default_nettype wire

// File: tb/tb_comp_sched.sv
`default_nettype none
// ============================================================================
// Module   : tb_comp_sched
// Purpose  : Self-checking bench for comp_sched. Directed scenarios followed
//            by randomized traffic, all checked each cycle against a
//            transaction-level reference model (grant pointer, one in-flight
//            job with its age, expected result from plain comparisons).
// Revision : 1.0 - initial release
// ============================================================================
module tb_comp_sched;

  localparam int DW   = 16;
  localparam int IDW  = 2;
  localparam int NREQ = 1 << IDW;

  logic                 Clk = 1'b0;
  logic                 Rst;
  logic [NREQ-1:0]      req_valid;
  logic [NREQ*DW-1:0]   req_a;
  logic [NREQ*DW-1:0]   req_b;
  logic [NREQ-1:0]      req_ready;
  logic                 rsp_valid;
  logic                 rsp_ready;
  logic [IDW-1:0]       rsp_id;
  logic                 rsp_gt;
  logic                 rsp_lt;
  logic                 rsp_eq;
  logic                 busy;

  comp_sched #(.DATAWIDTH(DW), .IDW(IDW)) u_dut (
    .Clk       (Clk),
    .Rst       (Rst),
    .req_valid (req_valid),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_ready (req_ready),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_id    (rsp_id),
    .rsp_gt    (rsp_gt),
    .rsp_lt    (rsp_lt),
    .rsp_eq    (rsp_eq),
    .busy      (busy)
  );

  always #5 Clk = ~Clk;

  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
    end
  endtask

  // Reference model state
  int          m_ptr   = 0;
  bit          m_known = 0;   // a reset edge has been seen
  bit          m_busy  = 0;   // a job is in flight
  int          m_age   = 0;   // cycles since the accepting edge
  int          m_id    = 0;
  logic [DW-1:0] m_a, m_b;
  bit          m_fresh = 0;   // no result registered since reset
  int          last_grant = -1;

  function automatic int rr_pick(input logic [NREQ-1:0] v, input int p);
    for (int k = 0; k < NREQ; k++) begin
      if (v[(p + k) % NREQ]) return (p + k) % NREQ;
    end
    return -1;
  endfunction

  // One clock cycle: inputs are already driven (just after negedge).
  task automatic step();
    int g;
    logic [NREQ-1:0] exp_ready;
    #1;
    g = (Rst && m_known && !m_busy) ? rr_pick(req_valid, m_ptr) : -1;
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready", 32'(req_ready), 32'(exp_ready));
    if (m_known) begin
      check("busy", 32'(busy), 32'(m_busy));
      check("rsp_valid", 32'(rsp_valid), 32'(m_busy && m_age >= 2));
      if (m_busy && m_age >= 2) begin
        check("rsp_id", 32'(rsp_id), 32'(m_id));
        check("rsp_gt", 32'(rsp_gt), 32'(m_a > m_b));
        check("rsp_lt", 32'(rsp_lt), 32'(m_a < m_b));
        check("rsp_eq", 32'(rsp_eq), 32'(m_a == m_b));
      end else if (m_fresh) begin
        check("rst_rsp_id", 32'(rsp_id), 32'd0);
        check("rst_flags", 32'({rsp_gt, rsp_lt, rsp_eq}), 32'd0);
      end
    end
    @(posedge Clk);
    last_grant = g;
    if (!Rst) begin
      m_known = 1; m_busy = 0; m_age = 0; m_ptr = 0; m_fresh = 1;
    end else if (g >= 0) begin
      m_busy = 1;
      m_age  = 1;
      m_id   = g;
      m_a    = req_a[g*DW +: DW];
      m_b    = req_b[g*DW +: DW];
      m_ptr  = (g + 1) % NREQ;
    end else if (m_busy) begin
      if (m_age == 1) begin
        m_age = 2; m_fresh = 0;
      end else if (rsp_ready) begin
        m_busy = 0;
      end
    end
    @(negedge Clk);
  endtask

  task automatic set_ops(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    req_a[i*DW +: DW] = a;
    req_b[i*DW +: DW] = b;
  endtask

  // Single directed transaction on requester i, bounded by a cycle budget.
  task automatic txn(input int i, input logic [DW-1:0] a, input logic [DW-1:0] b);
    bit done = 0;
    set_ops(i, a, b);
    req_valid = '0;
    req_valid[i] = 1'b1;
    for (int c = 0; c < 12 && !done; c++) begin
      step();
      if (last_grant == i) req_valid = '0;
      if (req_valid == '0 && !m_busy) done = 1;
    end
    check("txn_done", 32'(done), 32'd1);
  endtask

  task automatic gen_ops(output logic [DW-1:0] a, output logic [DW-1:0] b);
    case ($urandom_range(0, 6))
      0: begin a = DW'($urandom); b = a; end
      1: begin a = '0; b = '0; end
      2: begin a = '1; b = '1; end
      3: begin a = 16'h8000; b = 16'h7FFF; end
      4: begin a = '1; b = '0; end
      default: begin a = DW'($urandom); b = DW'($urandom); end
    endcase
    if ($urandom_range(0, 1) == 1) begin
      logic [DW-1:0] t;
      t = a; a = b; b = t;
    end
  endtask

  initial begin
    logic [DW-1:0] ra, rb;
    Rst       = 1'b0;
    req_valid = '1;
    req_a     = '0;
    req_b     = '0;
    rsp_ready = 1'b1;
    @(negedge Clk);
    // Reset with all requesters valid: nothing may be accepted.
    repeat (3) step();
    Rst = 1'b1;
    req_valid = '0;
    step();

    // Single request, equal operands, then unsigned corner cases.
    txn(2, 16'h1234, 16'h1234);
    txn(0, 16'h8000, 16'h7FFF);
    txn(0, 16'h7FFF, 16'h8000);
    txn(0, 16'hFFFF, 16'h0000);

    // Operand change after accept: result must reflect the latched pair.
    set_ops(1, 16'd5, 16'd9);
    req_valid = 4'b0010;
    for (int c = 0; c < 6 && last_grant != 1; c++) step();
    req_valid = '0;
    set_ops(1, 16'd20, 16'd9);
    repeat (4) step();

    // Fairness with all four persistently valid; rsp_ready held high.
    for (int i = 0; i < NREQ; i++) set_ops(i, DW'(16'h100 * i + 3), DW'(16'h180));
    req_valid = '1;
    rsp_ready = 1'b1;
    repeat (16) step();
    req_valid = '0;
    repeat (3) step();

    // Reset in the middle of a job, then requesters 3 and 0 together.
    txn(2, 16'd1, 16'd2);
    req_valid = 4'b0100;
    step();
    req_valid = '0;
    Rst = 1'b0;
    step();
    Rst = 1'b1;
    req_valid = 4'b1001;
    step();
    check("post_rst_grant", 32'(last_grant), 32'd0);
    req_valid = 4'b1000;
    repeat (4) step();
    req_valid = '0;
    repeat (4) step();

    // Randomized traffic with backpressure, drops and occasional reset.
    for (int n = 0; n < 3000; n++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (last_grant == i) begin
          if ($urandom_range(0, 1) == 0) req_valid[i] = 1'b0;
          gen_ops(ra, rb);
          set_ops(i, ra, rb);
        end else if (req_valid[i]) begin
          if ($urandom_range(0, 9) == 0) req_valid[i] = 1'b0;
        end else begin
          gen_ops(ra, rb);
          set_ops(i, ra, rb);
          if ($urandom_range(0, 9) < 3) req_valid[i] = 1'b1;
        end
      end
      rsp_ready = ($urandom_range(0, 9) < 6);
      Rst = ($urandom_range(0, 99) >= 2);
      step();
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
